wb_arbiter: RTL and testbench

Owns the single register-file write port of the MIPS pipeline and shares it between the in-order writeback stage and the multi-cycle multiply/divide unit. Pipeline results always win the port. Mult/div results wait in a 2-entry queue and drain into idle cycles. A starvation guard requests a one-cycle pipeline stall when queued results have waited too long.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_queue2.sv | 51 +++++
 rtl/wb_arbiter.sv | 129 ++++++++++++
 tb/tb_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the register-file write-port arbiter.
// Optional feature macro: WB_ARB_WAW_SQUASH_EN (consumed by wb_arbiter).
package wb_pkg;

    localparam int unsigned WB_AW = 5;
    localparam int unsigned WB_DW = 32;

    localparam logic [WB_AW-1:0] REG_ZERO = '0;

    // One queued mult/div result; live = 0 means it retires without writing.
    typedef struct packed {
        logic [WB_AW-1:0] rd;
        logic [WB_DW-1:0] data;
        logic             live;
    } wb_entry_t;

    typedef enum logic {
        NORMAL = 1'b0,
        STALL  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_queue2.sv
// wb_queue2: 2-entry FIFO of aux results with per-entry rd-match squash.
module wb_queue2
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    input  logic             squash,
    input  logic [WB_AW-1:0] squash_rd,
    output wb_entry_t        head,
    output logic [1:0]       count
);

    wb_entry_t mem [2];
    logic      rd_ptr;
    logic      wr_ptr;

    assign head = mem[rd_ptr];

    // Storage, pointers and occupancy; squash kills stored entries only.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (squash && (mem[i].rd == squash_rd)) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register-file write port between the writeback
// stage (always wins) and a 2-entry mult/div result queue, with a
// starvation guard that requests a one-cycle pipeline stall.
// Optional feature macro: WB_ARB_WAW_SQUASH_EN (pipe writes squash queued
// entries targeting the same register).
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned AW           = WB_AW,
    parameter int unsigned DW           = WB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pipe_valid,
    input  logic [AW-1:0] pipe_rd,
    input  logic [DW-1:0] pipe_data,
    input  logic          aux_valid,
    output logic          aux_ready,
    input  logic [AW-1:0] aux_rd,
    input  logic [DW-1:0] aux_data,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          stall_req,
    output logic [1:0]    q_count
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    wb_state_e        state;
    logic [CW-1:0]    starve_cnt;
    wb_entry_t        push_entry;
    wb_entry_t        head;
    logic             q_push;
    logic             q_pop;
    logic             q_empty;
    logic             squash;

    assign aux_ready = (q_count != 2'd2);
    assign q_empty   = (q_count == 2'd0);
    assign q_push    = aux_valid && aux_ready;
    assign q_pop     = !pipe_valid && !q_empty;

`ifdef WB_ARB_WAW_SQUASH_EN
    assign squash = pipe_valid && (pipe_rd != '0);
`else
    assign squash = 1'b0;
`endif

    // Incoming aux result packed into a queue entry.
    always_comb begin
        push_entry      = '0;
        push_entry.rd   = WB_AW'(aux_rd);
        push_entry.data = WB_DW'(aux_data);
        push_entry.live = 1'b1;
    end

    wb_queue2 u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (q_push),
        .push_entry (push_entry),
        .pop        (q_pop),
        .squash     (squash),
        .squash_rd  (WB_AW'(pipe_rd)),
        .head       (head),
        .count      (q_count)
    );

    // Write-port grant: pipe first, then queue head; r0 and dead entries never write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (pipe_valid) begin
            rf_we    <= (pipe_rd != '0);
            rf_waddr <= pipe_rd;
            rf_wdata <= pipe_data;
        end else if (q_pop) begin
            rf_we    <= head.live && (head.rd != REG_ZERO);
            rf_waddr <= AW'(head.rd);
            rf_wdata <= DW'(head.data);
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Starve counter and stall FSM; no stall is raised if the head drains this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= NORMAL;
            stall_req  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (q_pop || q_empty || (state == STALL)) begin
                starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
            case (state)
                NORMAL: begin
                    if ((starve_cnt == LIMIT) && !q_pop) begin
                        state     <= STALL;
                        stall_req <= 1'b1;
                    end else begin
                        stall_req <= 1'b0;
                    end
                end
                STALL: begin
                    state     <= NORMAL;
                    stall_req <= 1'b0;
                end
                default: begin
                    state     <= NORMAL;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline must idle the cycle after a stall request.
    a_stall_honoured: assert property (
        @(posedge clk) disable iff (reset) stall_req |=> !pipe_valid
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed bench for wb_arbiter with a write-order scoreboard.
// Honours WB_ARB_WAW_SQUASH_EN when it is defined for the build.
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_rd;
    logic [31:0] aux_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic [1:0]  q_count;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    wb_arbiter #(.STARVE_LIMIT(4), .AW(5), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .aux_valid  (aux_valid),
        .aux_ready  (aux_ready),
        .aux_rd     (aux_rd),
        .aux_data   (aux_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .stall_req  (stall_req),
        .q_count    (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        sb.push_back(e);
    endtask

    // Advance one cycle, sample after the edge and score any write.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (rf_we === 1'b1) begin
            vectors++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=r%0d/%0h expected=no write", rf_waddr, rf_wdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("wr_addr", 64'(rf_waddr), 64'(e.a));
                chk("wr_data", 64'(rf_wdata), 64'(e.d));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        pipe_valid = 1'b0;
        pipe_rd    = '0;
        pipe_data  = '0;
        aux_valid  = 1'b0;
        aux_rd     = '0;
        aux_data   = '0;
        tick();
        tick();
        chk("rst_we",        64'(rf_we),     64'd0);
        chk("rst_waddr",     64'(rf_waddr),  64'd0);
        chk("rst_wdata",     64'(rf_wdata),  64'd0);
        chk("rst_stall",     64'(stall_req), 64'd0);
        chk("rst_qcount",    64'(q_count),   64'd0);
        chk("rst_aux_ready", 64'(aux_ready), 64'd1);
        reset = 1'b0;

        // Pipe only: r8 writes, r0 is dropped.
        pipe_valid = 1'b1;
        pipe_rd    = 5'd8;
        pipe_data  = 32'h0000_1234;
        expect_wr(5'd8, 32'h0000_1234);
        tick();
        chk("pipe_we", 64'(rf_we), 64'd1);
        pipe_rd   = 5'd0;
        pipe_data = 32'h0000_5555;
        tick();
        chk("pipe_r0_we", 64'(rf_we), 64'd0);
        pipe_valid = 1'b0;
        tick();

        // Aux into idle port: written two cycles after acceptance.
        aux_valid = 1'b1;
        aux_rd    = 5'd2;
        aux_data  = 32'hDEAD_BEEF;
        chk("aux_ready_idle", 64'(aux_ready), 64'd1);
        expect_wr(5'd2, 32'hDEAD_BEEF);
        tick();
        aux_valid = 1'b0;
        chk("aux_q1",      64'(q_count), 64'd1);
        chk("aux_not_yet", 64'(rf_we),   64'd0);
        tick();
        chk("aux_we", 64'(rf_we),   64'd1);
        chk("aux_q0", 64'(q_count), 64'd0);

        // Full queue behind a busy pipe, third offer held, FIFO drain.
        pipe_valid = 1'b1;
        pipe_rd    = 5'd10;
        pipe_data  = 32'h0000_00A0;
        expect_wr(5'd10, 32'h0000_00A0);
        aux_valid  = 1'b1;
        aux_rd     = 5'd3;
        aux_data   = 32'h0000_0033;
        tick();
        pipe_rd   = 5'd11;
        pipe_data = 32'h0000_00A1;
        expect_wr(5'd11, 32'h0000_00A1);
        aux_rd    = 5'd4;
        aux_data  = 32'h0000_0044;
        tick();
        chk("full_q2",    64'(q_count),   64'd2);
        chk("full_ready", 64'(aux_ready), 64'd0);
        pipe_rd   = 5'd12;
        pipe_data = 32'h0000_00A2;
        expect_wr(5'd12, 32'h0000_00A2);
        aux_rd    = 5'd6;
        aux_data  = 32'h0000_0066;
        tick();
        chk("full_held_q2", 64'(q_count), 64'd2);
        pipe_valid = 1'b0;
        expect_wr(5'd3, 32'h0000_0033);
        expect_wr(5'd4, 32'h0000_0044);
        expect_wr(5'd6, 32'h0000_0066);
        tick();
        chk("drain1_q1",    64'(q_count),   64'd1);
        chk("drain1_ready", 64'(aux_ready), 64'd1);
        tick();
        aux_valid = 1'b0;
        chk("drain2_q1", 64'(q_count), 64'd1);
        tick();
        chk("drain3_q0", 64'(q_count), 64'd0);

        // Starvation: one queued entry behind a continuous pipe.
        aux_valid  = 1'b1;
        aux_rd     = 5'd7;
        aux_data   = 32'h0000_0077;
        pipe_valid = 1'b1;
        pipe_rd    = 5'd9;
        for (int k = 0; k < 6; k++) begin
            pipe_data = 32'h0000_0900 + 32'(k);
            expect_wr(5'd9, 32'h0000_0900 + 32'(k));
            tick();
            aux_valid = 1'b0;
            chk($sformatf("starve_stall_%0d", k), 64'(stall_req), (k == 5) ? 64'd1 : 64'd0);
        end
        pipe_valid = 1'b0;
        expect_wr(5'd7, 32'h0000_0077);
        tick();
        chk("starve_stall_drop", 64'(stall_req), 64'd0);
        chk("starve_we",         64'(rf_we),     64'd1);
        chk("starve_q0",         64'(q_count),   64'd0);
        tick();

        // WAW: queued r5/0x11 overtaken by pipe r5/0x22.
        aux_valid = 1'b1;
        aux_rd    = 5'd5;
        aux_data  = 32'h0000_0011;
        tick();
        aux_valid  = 1'b0;
        pipe_valid = 1'b1;
        pipe_rd    = 5'd5;
        pipe_data  = 32'h0000_0022;
        expect_wr(5'd5, 32'h0000_0022);
        tick();
        chk("waw_pipe_data", 64'(rf_wdata), 64'h22);
        chk("waw_q1",        64'(q_count),  64'd1);
        pipe_valid = 1'b0;
`ifndef WB_ARB_WAW_SQUASH_EN
        expect_wr(5'd5, 32'h0000_0011);
`endif
        tick();
`ifdef WB_ARB_WAW_SQUASH_EN
        chk("waw_pop_we", 64'(rf_we), 64'd0);
`else
        chk("waw_pop_we", 64'(rf_we), 64'd1);
`endif
        chk("waw_q0", 64'(q_count), 64'd0);

        // Reset with two entries queued and a stall about to fire.
        pipe_valid = 1'b1;
        pipe_rd    = 5'd12;
        for (int k = 0; k < 5; k++) begin
            aux_valid = (k < 2);
            aux_rd    = 5'(13 + k);
            aux_data  = 32'h0000_0013 + 32'(k);
            pipe_data = 32'h0000_0C00 + 32'(k);
            expect_wr(5'd12, 32'h0000_0C00 + 32'(k));
            tick();
        end
        aux_valid = 1'b0;
        chk("pre_rst_q2",    64'(q_count),   64'd2);
        chk("pre_rst_stall", 64'(stall_req), 64'd0);
        reset      = 1'b1;
        pipe_valid = 1'b0;
        tick();
        chk("mid_rst_q0",    64'(q_count),   64'd0);
        chk("mid_rst_stall", 64'(stall_req), 64'd0);
        chk("mid_rst_we",    64'(rf_we),     64'd0);
        chk("mid_rst_ready", 64'(aux_ready), 64'd1);
        reset = 1'b0;
        tick();
        tick();
        chk("post_rst_stall", 64'(stall_req), 64'd0);
        chk("post_rst_we",    64'(rf_we),     64'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
